// File: rtl/pc_fetch_pkg.sv
// pc_fetch shared types and constants.
// Fetch FSM encoding and instruction width in bytes.
package FetchStatesPackage;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    REQUEST = 2'h1,
    HOLD    = 2'h2,
    FAULT   = 2'h3
  } FetchStates;

  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

endpackage

// File: rtl/pc_fetch_watchdog.sv
// fetch_watchdog: counts REQUEST cycles without memReady.
// expired flags the last cycle before a fetch timeout.
module fetch_watchdog #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // clear has priority so a fresh request always starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // wait counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and instruction fetch stage.
// Fetches one word per instruction, holds it for decode.
module pc_fetch
  import FetchStatesPackage::*;
#(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        stall,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  output logic [31:0] memAddress,
  output logic        memRequest,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic [31:0] pcAddress,
  output logic        fault
);

  FetchStates  state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] instr_q, instr_d;

  logic wd_clear;
  logic wd_count;
  logic wd_expired;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .count  (wd_count),
    .expired(wd_expired)
  );

  // next-state, register updates and handshake outputs
  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    fetch_addr_d     = fetch_addr_q;
    instr_d          = instr_q;
    wd_clear         = 1'b0;
    wd_count         = 1'b0;
    memRequest       = 1'b0;
    instructionValid = 1'b0;
    fault            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = REQUEST;
          wd_clear = 1'b1;
        end
      end
      REQUEST: begin
        memRequest = 1'b1;
        if (memReady) begin
          instr_d    = memData;
          cur_addr_d = fetch_addr_q;
          state_d    = HOLD;
        end else if (wd_expired) begin
          state_d = FAULT;
        end else begin
          wd_count = 1'b1;
        end
      end
      HOLD: begin
        instructionValid = 1'b1;
        if (!stall) begin
          // misaligned target never reaches memory
          if (shouldUseNewPC && (branchTo[1:0] != 2'b00)) begin
            state_d = FAULT;
          end else begin
            fetch_addr_d = shouldUseNewPC ? branchTo
                         : cur_addr_q + INSTRUCTION_BYTES;
            state_d      = enable ? REQUEST : IDLE;
            wd_clear     = enable;
          end
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= RESET_VECTOR;
      fetch_addr_q <= RESET_VECTOR;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
    end
  end

  assign memAddress  = fetch_addr_q;
  assign instruction = instr_q;
  assign pcAddress   = cur_addr_q + INSTRUCTION_BYTES;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch.
// Two instances: timeout 4 at vector 0, and a wrapping vector.
module tb_pc_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // instance A: RESET_VECTOR=0, FETCH_TIMEOUT=4
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        snp = 1'b0;
  logic [31:0] bto = '0;
  logic [31:0] maddr;
  logic        mreq;
  logic        auto_rdy = 1'b1;
  logic        man_rdy = 1'b0;
  logic        mrdy;
  logic [31:0] mdata;
  logic [31:0] instr;
  logic        ivalid;
  logic [31:0] pca;
  logic        flt;

  assign mrdy  = auto_rdy ? mreq : man_rdy;
  assign mdata = word_at(maddr);

  pc_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .FETCH_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .stall           (stall),
    .shouldUseNewPC  (snp),
    .branchTo        (bto),
    .memAddress      (maddr),
    .memRequest      (mreq),
    .memReady        (mrdy),
    .memData         (mdata),
    .instruction     (instr),
    .instructionValid(ivalid),
    .pcAddress       (pca),
    .fault           (flt)
  );

  // instance B: RESET_VECTOR=FFFF_FFFC, default timeout
  logic        rst2 = 1'b0;
  logic        enable2 = 1'b0;
  logic [31:0] maddr2;
  logic        mreq2;
  logic [31:0] instr2;
  logic        ivalid2;
  logic [31:0] pca2;
  logic        flt2;

  pc_fetch #(
    .RESET_VECTOR (32'hFFFF_FFFC),
    .FETCH_TIMEOUT(16)
  ) dut2 (
    .clk             (clk),
    .rst             (rst2),
    .enable          (enable2),
    .stall           (1'b0),
    .shouldUseNewPC  (1'b0),
    .branchTo        (32'h0),
    .memAddress      (maddr2),
    .memRequest      (mreq2),
    .memReady        (mreq2),
    .memData         (word_at(maddr2)),
    .instruction     (instr2),
    .instructionValid(ivalid2),
    .pcAddress       (pca2),
    .fault           (flt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (mreq !== 1'b0) $display("FAIL rst_req got %b want 0", mreq);
    else n_pass++;
    n_total++;
    if (maddr !== 32'h0) $display("FAIL rst_addr got %h want 0", maddr);
    else n_pass++;
    n_total++;
    if (instr !== 32'h0) $display("FAIL rst_instr got %h want 0", instr);
    else n_pass++;
    n_total++;
    if (ivalid !== 1'b0) $display("FAIL rst_valid got %b want 0", ivalid);
    else n_pass++;
    n_total++;
    if (pca !== 32'h4) $display("FAIL rst_pc got %h want 4", pca);
    else n_pass++;
    n_total++;
    if (flt !== 1'b0) $display("FAIL rst_fault got %b want 0", flt);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++;
    if (mreq !== 1'b0) $display("FAIL idle_req got %b want 0", mreq);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      n_total++;
      if (mreq !== 1'b1 || maddr !== a || ivalid !== 1'b0)
        $display("FAIL seq_req%0d got req=%b addr=%h v=%b want 1 %h 0",
                 i, mreq, maddr, ivalid, a);
      else n_pass++;
      tick();
      n_total++;
      if (ivalid !== 1'b1 || mreq !== 1'b0 || pca !== a + 32'h4
          || instr !== word_at(a))
        $display("FAIL seq_hold%0d got v=%b pc=%h in=%h want 1 %h %h",
                 i, ivalid, pca, instr, a + 32'h4, word_at(a));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    // enters with the fetch of 0xC outstanding
    tick();
    snp = 1'b1;
    bto = 32'h0000_0100;
    tick();
    snp = 1'b0;
    bto = 32'h0;
    n_total++;
    if (mreq !== 1'b1 || maddr !== 32'h100)
      $display("FAIL redir_addr got req=%b addr=%h want 1 100", mreq, maddr);
    else n_pass++;
    tick();
    n_total++;
    if (ivalid !== 1'b1 || pca !== 32'h104 || instr !== word_at(32'h100))
      $display("FAIL redir_pc got v=%b pc=%h in=%h want 1 104 %h",
               ivalid, pca, instr, word_at(32'h100));
    else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    bto = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      snp = i[0];
      tick();
      n_total++;
      if (ivalid !== 1'b1 || mreq !== 1'b0 || pca !== 32'h104
          || instr !== word_at(32'h100))
        $display("FAIL stall%0d got v=%b req=%b pc=%h in=%h", i,
                 ivalid, mreq, pca, instr);
      else n_pass++;
    end
    stall = 1'b0;
    snp = 1'b0;
    tick();
    n_total++;
    if (mreq !== 1'b1 || maddr !== 32'h104)
      $display("FAIL stall_release got req=%b addr=%h want 1 104",
               mreq, maddr);
    else n_pass++;
    tick();
    n_total++;
    if (pca !== 32'h108) $display("FAIL stall_next_pc got %h want 108", pca);
    else n_pass++;
  endtask

  task automatic test_timeout();
    auto_rdy = 1'b0;
    man_rdy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    n_total++;
    if (flt !== 1'b0 || ivalid !== 1'b1 || instr !== word_at(32'h108))
      $display("FAIL late_ready got f=%b v=%b in=%h want 0 1 %h",
               flt, ivalid, instr, word_at(32'h108));
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (flt !== 1'b0 || mreq !== 1'b1 || maddr !== 32'h10C)
      $display("FAIL to_pre got f=%b req=%b addr=%h want 0 1 10c",
               flt, mreq, maddr);
    else n_pass++;
    tick();
    n_total++;
    if (flt !== 1'b1 || mreq !== 1'b0 || ivalid !== 1'b0)
      $display("FAIL timeout got f=%b req=%b v=%b want 1 0 0",
               flt, mreq, ivalid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (flt !== 1'b0 || maddr !== 32'h0 || mreq !== 1'b0)
      $display("FAIL to_reset got f=%b addr=%h req=%b want 0 0 0",
               flt, maddr, mreq);
    else n_pass++;
    tick();
    rst = 1'b1;
    auto_rdy = 1'b1;
  endtask

  task automatic test_misaligned();
    tick();
    tick();
    snp = 1'b1;
    bto = 32'h0000_0102;
    enable = 1'b0;
    tick();
    snp = 1'b0;
    enable = 1'b1;
    n_total++;
    if (flt !== 1'b1 || mreq !== 1'b0)
      $display("FAIL misalign got f=%b req=%b want 1 0", flt, mreq);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (flt !== 1'b1 || mreq !== 1'b0 || ivalid !== 1'b0)
      $display("FAIL sticky got f=%b req=%b v=%b want 1 0 0",
               flt, mreq, ivalid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (flt !== 1'b0 || maddr !== 32'h0)
      $display("FAIL ma_reset got f=%b addr=%h want 0 0", flt, maddr);
    else n_pass++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_enable_drop();
    auto_rdy = 1'b0;
    man_rdy = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    n_total++;
    if (mreq !== 1'b1 || maddr !== 32'h0)
      $display("FAIL en_drop_req got req=%b addr=%h want 1 0", mreq, maddr);
    else n_pass++;
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    n_total++;
    if (ivalid !== 1'b1) $display("FAIL en_drop_hold got %b want 1", ivalid);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (mreq !== 1'b0 || ivalid !== 1'b0 || maddr !== 32'h4)
      $display("FAIL en_drop_idle got req=%b v=%b addr=%h want 0 0 4",
               mreq, ivalid, maddr);
    else n_pass++;
    auto_rdy = 1'b1;
  endtask

  task automatic test_wrap();
    n_total++;
    if (maddr2 !== 32'hFFFF_FFFC || pca2 !== 32'h0)
      $display("FAIL wrap_rst got addr=%h pc=%h want fffffffc 0",
               maddr2, pca2);
    else n_pass++;
    rst2 = 1'b1;
    enable2 = 1'b1;
    tick();
    tick();
    n_total++;
    if (ivalid2 !== 1'b1 || pca2 !== 32'h0
        || instr2 !== word_at(32'hFFFF_FFFC))
      $display("FAIL wrap_hold got v=%b pc=%h in=%h want 1 0 %h",
               ivalid2, pca2, instr2, word_at(32'hFFFF_FFFC));
    else n_pass++;
    tick();
    n_total++;
    if (mreq2 !== 1'b1 || maddr2 !== 32'h0 || flt2 !== 1'b0)
      $display("FAIL wrap_next got req=%b addr=%h f=%b want 1 0 0",
               mreq2, maddr2, flt2);
    else n_pass++;
    #2;
    rst2 = 1'b0;
    #1;
    n_total++;
    if (mreq2 !== 1'b0 || maddr2 !== 32'hFFFF_FFFC)
      $display("FAIL wrap_abort got req=%b addr=%h want 0 fffffffc",
               mreq2, maddr2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_timeout();
    test_misaligned();
    test_enable_drop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
